// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multicycle sequencer and memory.
// The controller is the master: it raises mem_req and chooses the address source.
// Memory is the slave: it answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic mem_addr_sel;
  logic mem_write_en;

  modport master (
    output mem_req,
    output mem_addr_sel,
    output mem_write_en,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr_sel,
    input  mem_write_en,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/BRANCH/JUMP/ERROR.
// Handles R-type, lw, sw, beq and j over one shared memory port.
// The memory port has a wait-state watchdog; MEM_TIMEOUT = 0 disables it.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN.
//   When it is defined, an unsupported opcode sets a sticky illegal_instr flag and the FSM enters ERROR.
//   When it is undefined, an unsupported opcode retires as a NOP.
// Control outputs are decoded combinationally from the state and the latched opcode.
// The FETCH and MEM enables also depend on mem_ready.
// All control outputs are held low while reset is high.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_ctrl_if.master        mem,
  input  logic [5:0]               instrn_opcode,
  input  logic                     zero_out,
  output logic                     ir_write_en,
  output logic                     pc_write_en,
  output logic [1:0]               pc_src,
  output logic                     alu_src,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     reg_write_en,
  output logic [2:0]               state_o,
  output logic [31:0]              instr_retired,
  output logic                     mem_error
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic                     illegal_instr
`endif
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_JUMP      = 3'd6,
    S_ERROR     = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     opcode_q, opcode_d;
  logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                mem_error_q, mem_error_d;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic                illegal_q, illegal_d;
`endif

  // Raw (ungated) control decode
  logic                mem_req_c;
  logic                mem_addr_sel_c;
  logic                mem_write_en_c;
  logic                ir_write_en_c;
  logic                pc_write_en_c;
  logic [1:0]          pc_src_c;
  logic                alu_src_c;
  logic                reg_dst_c;
  logic                mem_to_reg_c;
  logic                reg_write_en_c;

  logic                retire_c;
  logic                wd_expire_c;
  logic                mem_wait_c;

  // Watchdog fires on the wait cycle whose increment would reach MEM_TIMEOUT.
  always_comb begin
    wd_expire_c = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      wd_expire_c = (wait_cnt_q == TO_W'(MEM_TIMEOUT - 1));
    end
  end

  // Next-state, datapath enables and retire decode
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    mem_error_d    = mem_error_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_d      = illegal_q;
`endif
    mem_req_c      = 1'b0;
    mem_addr_sel_c = 1'b0;
    mem_write_en_c = 1'b0;
    ir_write_en_c  = 1'b0;
    pc_write_en_c  = 1'b0;
    pc_src_c       = PC_SRC_SEQ;
    alu_src_c      = 1'b0;
    reg_dst_c      = 1'b0;
    mem_to_reg_c   = 1'b0;
    reg_write_en_c = 1'b0;
    retire_c       = 1'b0;
    mem_wait_c     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_write_en_c = 1'b1;
          pc_write_en_c = 1'b1;
          state_d       = S_DECODE;
        end else if (wd_expire_c) begin
          mem_error_d = 1'b1;
          state_d     = S_ERROR;
        end else begin
          mem_wait_c = 1'b1;
        end
      end

      S_DECODE: begin
        opcode_d = instrn_opcode;
        if (instrn_opcode == OP_RTYPE || instrn_opcode == OP_LW || instrn_opcode == OP_SW) begin
          state_d = S_EXECUTE;
        end else if (instrn_opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (instrn_opcode == OP_J) begin
          state_d = S_JUMP;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_ERROR;
`else
          retire_c  = 1'b1;
          state_d   = S_FETCH;
`endif
        end
      end

      S_EXECUTE: begin
        alu_src_c = (opcode_q != OP_RTYPE);
        state_d   = (opcode_q == OP_RTYPE) ? S_WRITEBACK : S_MEM;
      end

      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        alu_src_c      = 1'b1;
        mem_write_en_c = (opcode_q == OP_SW);
        if (mem.mem_ready) begin
          if (opcode_q == OP_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WRITEBACK;
          end
        end else if (wd_expire_c) begin
          mem_error_d = 1'b1;
          state_d     = S_ERROR;
        end else begin
          mem_wait_c = 1'b1;
        end
      end

      S_WRITEBACK: begin
        reg_write_en_c = 1'b1;
        reg_dst_c      = (opcode_q == OP_RTYPE);
        mem_to_reg_c   = (opcode_q == OP_LW);
        retire_c       = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        pc_src_c      = PC_SRC_BRANCH;
        pc_write_en_c = zero_out;
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_src_c      = PC_SRC_JUMP;
        pc_write_en_c = 1'b1;
        retire_c      = 1'b1;
        state_d       = S_FETCH;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // Wait counter restarts on every state change and counts stalled FETCH/MEM cycles
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait_c && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + TO_W'(1);
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_comb begin
    retired_d = retired_q;
    if (retire_c) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Sequencer state, opcode latch, counters and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      opcode_q    <= '0;
      wait_cnt_q  <= '0;
      retired_q   <= '0;
      mem_error_q <= 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      wait_cnt_q  <= wait_cnt_d;
      retired_q   <= retired_d;
      mem_error_q <= mem_error_d;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  // Hold every control output low while reset is high so no access or write leaks out
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_addr_sel = 1'b0;
    mem.mem_write_en = 1'b0;
    ir_write_en      = 1'b0;
    pc_write_en      = 1'b0;
    pc_src           = PC_SRC_SEQ;
    alu_src          = 1'b0;
    reg_dst          = 1'b0;
    mem_to_reg       = 1'b0;
    reg_write_en     = 1'b0;
    if (!reset) begin
      mem.mem_req      = mem_req_c;
      mem.mem_addr_sel = mem_addr_sel_c;
      mem.mem_write_en = mem_write_en_c;
      ir_write_en      = ir_write_en_c;
      pc_write_en      = pc_write_en_c;
      pc_src           = pc_src_c;
      alu_src          = alu_src_c;
      reg_dst          = reg_dst_c;
      mem_to_reg       = mem_to_reg_c;
      reg_write_en     = reg_write_en_c;
    end
  end

  assign state_o       = state_q;
  assign instr_retired = retired_q;
  assign mem_error     = mem_error_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (MEM_TIMEOUT = 4).
// Each step drives the inputs and then checks state and controls in the same cycle before the next rising edge.
// Control vector bit layout: {req, asel, mwe, irw, pcw, pc_src[1:0], alu, rdst, m2r, rwe}.
module tb_multicycle_ctrl;

  localparam logic [10:0] C_NONE = 11'h000;
  localparam logic [10:0] B_REQ  = 11'h400;
  localparam logic [10:0] B_ASEL = 11'h200;
  localparam logic [10:0] B_MWE  = 11'h100;
  localparam logic [10:0] B_IRW  = 11'h080;
  localparam logic [10:0] B_PCW  = 11'h040;
  localparam logic [10:0] B_PCJ  = 11'h020;
  localparam logic [10:0] B_PCB  = 11'h010;
  localparam logic [10:0] B_ALU  = 11'h008;
  localparam logic [10:0] B_RDST = 11'h004;
  localparam logic [10:0] B_M2R  = 11'h002;
  localparam logic [10:0] B_RWE  = 11'h001;

  localparam logic [10:0] C_FETCH_RDY = B_REQ | B_IRW | B_PCW;
  localparam logic [10:0] C_FETCH_WT  = B_REQ;
  localparam logic [10:0] C_MEM_LW    = B_REQ | B_ASEL | B_ALU;
  localparam logic [10:0] C_MEM_SW    = B_REQ | B_ASEL | B_MWE | B_ALU;
  localparam logic [10:0] C_WB_R      = B_RWE | B_RDST;
  localparam logic [10:0] C_WB_LW     = B_RWE | B_M2R;

  logic        clk;
  logic        reset;
  logic [5:0]  instrn_opcode;
  logic        zero_out;
  logic        ir_write_en;
  logic        pc_write_en;
  logic [1:0]  pc_src;
  logic        alu_src;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write_en;
  logic [2:0]  state_o;
  logic [31:0] instr_retired;
  logic        mem_error;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic        illegal_instr;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(
    .MEM_TIMEOUT (4),
    .TO_W        (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mif.master),
    .instrn_opcode (instrn_opcode),
    .zero_out      (zero_out),
    .ir_write_en   (ir_write_en),
    .pc_write_en   (pc_write_en),
    .pc_src        (pc_src),
    .alu_src       (alu_src),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write_en  (reg_write_en),
    .state_o       (state_o),
    .instr_retired (instr_retired),
    .mem_error     (mem_error)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  logic [10:0] act_ctl;
  assign act_ctl = {mif.mem_req, mif.mem_addr_sel, mif.mem_write_en, ir_write_en,
                    pc_write_en, pc_src, alu_src, reg_dst, mem_to_reg, reg_write_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check state and controls for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [10:0] ctl);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctl"}, 32'(act_ctl), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    mif.mem_ready = 1'b0;
    instrn_opcode = 6'h00;
    zero_out      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.ctl", 32'(act_ctl), 32'(C_NONE));
    chk("rst.retired", instr_retired, 32'd0);
    chk("rst.mem_error", 32'(mem_error), 32'd0);
    reset = 1'b0;

    // R-type with memory always ready
    mif.mem_ready = 1'b1;
    instrn_opcode = 6'h00;
    cyc("r.fetch", 3'd0, C_FETCH_RDY);
    cyc("r.decode", 3'd1, C_NONE);
    cyc("r.exec", 3'd2, C_NONE);
    cyc("r.wb", 3'd4, C_WB_R);
    chk("r.retired", instr_retired, 32'd1);

    // lw with three wait states in MEM; the last wait lands on the timeout boundary
    instrn_opcode = 6'h23;
    cyc("lw.fetch", 3'd0, C_FETCH_RDY);
    cyc("lw.decode", 3'd1, C_NONE);
    mif.mem_ready = 1'b0;
    cyc("lw.exec", 3'd2, B_ALU);
    cyc("lw.mem_w1", 3'd3, C_MEM_LW);
    cyc("lw.mem_w2", 3'd3, C_MEM_LW);
    cyc("lw.mem_w3", 3'd3, C_MEM_LW);
    mif.mem_ready = 1'b1;
    cyc("lw.mem_rdy", 3'd3, C_MEM_LW);
    chk("lw.retired_before_wb", instr_retired, 32'd1);
    cyc("lw.wb", 3'd4, C_WB_LW);
    chk("lw.retired", instr_retired, 32'd2);
    chk("lw.no_error", 32'(mem_error), 32'd0);

    // beq taken, then beq not taken
    instrn_opcode = 6'h04;
    zero_out      = 1'b1;
    cyc("beq1.fetch", 3'd0, C_FETCH_RDY);
    cyc("beq1.decode", 3'd1, C_NONE);
    cyc("beq1.branch", 3'd5, B_PCB | B_PCW);
    zero_out = 1'b0;
    cyc("beq0.fetch", 3'd0, C_FETCH_RDY);
    cyc("beq0.decode", 3'd1, C_NONE);
    cyc("beq0.branch", 3'd5, B_PCB);
    chk("beq.retired", instr_retired, 32'd4);

    // sw then j
    instrn_opcode = 6'h2B;
    cyc("sw.fetch", 3'd0, C_FETCH_RDY);
    cyc("sw.decode", 3'd1, C_NONE);
    cyc("sw.exec", 3'd2, B_ALU);
    cyc("sw.mem", 3'd3, C_MEM_SW);
    chk("sw.retired", instr_retired, 32'd5);
    instrn_opcode = 6'h02;
    cyc("j.fetch", 3'd0, C_FETCH_RDY);
    cyc("j.decode", 3'd1, C_NONE);
    cyc("j.jump", 3'd6, B_PCJ | B_PCW);
    chk("j.retired", instr_retired, 32'd6);

    // Unsupported opcode
    instrn_opcode = 6'h3F;
    cyc("ill.fetch", 3'd0, C_FETCH_RDY);
    cyc("ill.decode", 3'd1, C_NONE);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk("ill.state", 32'(state_o), 32'd7);
    chk("ill.flag", 32'(illegal_instr), 32'd1);
    chk("ill.retired", instr_retired, 32'd6);
    cyc("ill.hold", 3'd7, C_NONE);
    chk("ill.flag_sticky", 32'(illegal_instr), 32'd1);
`else
    chk("nop.state", 32'(state_o), 32'd0);
    chk("nop.retired", instr_retired, 32'd7);
`endif

    // Restart from reset, then FETCH watchdog expiry
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2.ctl", 32'(act_ctl), 32'(C_NONE));
    chk("rst2.retired", instr_retired, 32'd0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    chk("rst2.illegal", 32'(illegal_instr), 32'd0);
`endif
    reset         = 1'b0;
    mif.mem_ready = 1'b0;
    cyc("wd.w1", 3'd0, C_FETCH_WT);
    cyc("wd.w2", 3'd0, C_FETCH_WT);
    cyc("wd.w3", 3'd0, C_FETCH_WT);
    cyc("wd.w4", 3'd0, C_FETCH_WT);
    chk("wd.mem_error", 32'(mem_error), 32'd1);
    mif.mem_ready = 1'b1;
    cyc("wd.err_hold1", 3'd7, C_NONE);
    cyc("wd.err_hold2", 3'd7, C_NONE);
    chk("wd.err_sticky", 32'(mem_error), 32'd1);
    chk("wd.retired_frozen", instr_retired, 32'd0);

    // Ready arrives on the 4th wait cycle: it takes priority over the timeout
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst3.mem_error", 32'(mem_error), 32'd0);
    reset         = 1'b0;
    mif.mem_ready = 1'b0;
    instrn_opcode = 6'h02;
    cyc("wdr.w1", 3'd0, C_FETCH_WT);
    cyc("wdr.w2", 3'd0, C_FETCH_WT);
    cyc("wdr.w3", 3'd0, C_FETCH_WT);
    mif.mem_ready = 1'b1;
    cyc("wdr.rdy", 3'd0, C_FETCH_RDY);
    cyc("wdr.decode", 3'd1, C_NONE);
    cyc("wdr.jump", 3'd6, B_PCJ | B_PCW);
    chk("wdr.no_error", 32'(mem_error), 32'd0);
    chk("wdr.retired", instr_retired, 32'd1);

    // Reset in the middle of a stalled lw memory access
    instrn_opcode = 6'h23;
    cyc("mid.fetch", 3'd0, C_FETCH_RDY);
    cyc("mid.decode", 3'd1, C_NONE);
    mif.mem_ready = 1'b0;
    cyc("mid.exec", 3'd2, B_ALU);
    cyc("mid.mem_w1", 3'd3, C_MEM_LW);
    reset         = 1'b1;
    mif.mem_ready = 1'b1;
    #1;
    chk("mid.rst_gate_ctl", 32'(act_ctl), 32'(C_NONE));
    @(posedge clk);
    #1;
    chk("mid.rst_state", 32'(state_o), 32'd0);
    chk("mid.rst_ctl", 32'(act_ctl), 32'(C_NONE));
    chk("mid.rst_retired", instr_retired, 32'd0);
    reset = 1'b0;
    cyc("mid.refetch", 3'd0, C_FETCH_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath.
- Decodes opcode from the instruction register and drives PC, IR, register-file, ALU-mux and memory-port enables state by state.
- Supports R-type (0x00), lw (0x23), sw (0x2B), beq (0x04) and j (0x02).
- Shares one memory port between instruction fetch and data access via a req/ready handshake, with a wait-state watchdog.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before entering ERROR; 0 disables the watchdog.
TO_W, 8, width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
instrn_opcode  input  6  opcode bits [31:26] from the IR
zero_out  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
mem_addr_sel  output  1  0 = PC address, 1 = ALU result address
mem_write_en  output  1  store strobe
ir_write_en  output  1  load IR
pc_write_en  output  1  update PC
pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target
alu_src  output  1  1 = sign-extended immediate
reg_dst  output  1  1 = rd [15:11], 0 = rt [20:16]
mem_to_reg  output  1  1 = memory read data to register file
reg_write_en  output  1  register-file write
state_o  output  3  current state
instr_retired  output  32  retired-instruction count
mem_error  output  1  sticky watchdog flag

Behaviour:
- Reset is synchronous and active-high. While reset is high:
  - state := FETCH; opcode latch, wait counter and instr_retired := 0; mem_error := 0.
  - All control outputs are forced to 0.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, BRANCH=5, JUMP=6, ERROR=7.
- Outputs are combinational from state and the latched opcode; enables not listed for a state are 0.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_write_en=1, pc_write_en=1, pc_src=0, next state DECODE.
  - Otherwise hold.
- DECODE:
  - One cycle; latch instrn_opcode.
  - 0x00/0x23/0x2B -> EXECUTE; 0x04 -> BRANCH; 0x02 -> JUMP; any other opcode -> see Optional Feature.
- EXECUTE:
  - One cycle; alu_src=1 for lw/sw, 0 for R-type.
  - R-type -> WRITEBACK; lw/sw -> MEM.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_src=1, mem_write_en=1 for sw only.
  - On mem_ready: sw retires -> FETCH; lw -> WRITEBACK.
- WRITEBACK:
  - reg_write_en=1.
  - R-type: reg_dst=1, mem_to_reg=0. lw: reg_dst=0, mem_to_reg=1.
  - Retire -> FETCH.
- BRANCH: pc_src=1, pc_write_en=zero_out; retire -> FETCH.
- JUMP: pc_src=2, pc_write_en=1; retire -> FETCH.
- Retire: instr_retired increments by 1 on the exiting cycle; wraps 0xFFFFFFFF -> 0.
- Latencies from FETCH entry, with zero wait states:
  - R-type 4 cycles; lw 5; sw 4; beq 3; j 3.
  - Each wait state adds 1 cycle.
- Watchdog:
  - The counter clears on entering FETCH or MEM and increments each cycle in those states without mem_ready.
  - When the counter reaches MEM_TIMEOUT: mem_error := 1, state -> ERROR.
  - mem_ready in the same cycle as the timeout wins: normal transition, no error.
- ERROR:
  - All enables 0; state and mem_error are held until reset.
  - instr_retired is frozen.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-access:
  - The next cycle is FETCH with mem_req=0 while reset is high.
  - A pending access is abandoned; no register or PC write occurs.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_instr (1 bit, sticky, cleared by reset).
  - An unsupported opcode in DECODE sets illegal_instr := 1 and enters ERROR; the instruction does not retire.
- Undefined:
  - An unsupported opcode is a NOP: DECODE -> FETCH, retires (instr_retired +1), and no PC, register or memory write occurs.

Test Plan:
- Reset, then R-type (opcode 0x00), mem_ready tied 1 -> states 0,1,2,4,0; reg_write_en=1 with reg_dst=1 in cycle 4; instr_retired=1.
- lw (0x23), mem_ready delayed 3 cycles in MEM -> mem_req/mem_addr_sel=1 held 4 cycles; WRITEBACK has mem_to_reg=1, reg_dst=0; total 8 cycles.
- beq (0x04) with zero_out=1, then zero_out=0 -> pc_write_en=1 with pc_src=1 only in the first case; both retire, count=2.
- sw (0x2B) then j (0x02) -> mem_write_en=1 for exactly the MEM ready cycle; JUMP has pc_src=2, pc_write_en=1; no reg_write_en.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERROR (state_o=7) after 4 wait cycles; mem_error=1 until reset. Repeat with mem_ready rising on the 4th wait cycle -> no error.
- Opcode 0x3F -> with MULTICYCLE_ILLEGAL_TRAP_EN: illegal_instr=1, state 7, count unchanged. Without it: return to FETCH, count +1, no write enables.
